// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch
// Pixel fetch stage placed directly after the VGA timing generator.
// Turns hcnt/vcnt into frame-buffer read addresses for a 2x upscaled
// 320x240 RGB444 image. Delays syncs, blank and the frame-origin flag
// so that they line up with the returned pixel data. Flips the
// displayed bank only on the first clock of vertical blank, and only
// when the writer has asked for a flip.
module vga_pixel_fetch #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SCALE_SHIFT = 1,
  parameter int FB_WIDTH    = 320,
  parameter int ADDR_W      = 17,
  parameter int RD_LAT      = 2
) (
  input  logic              CLK25,
  input  logic              reset,
  input  logic [10:0]       hcnt,
  input  logic [10:0]       vcnt,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              fb_swap_req,
  output logic              fb_swap_ack,
  output logic              rd_bank,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [11:0]       rd_data,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic              vga_blank_n,
  output logic              frame_start
);

  // The address register is stage 1 and the output register is stage LAT.
  // The side-band signals therefore need LAT-1 intermediate stages.
  localparam int LAT    = RD_LAT + 2;
  localparam int PIPE_D = LAT - 1;

  localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM = 11'(V_ACTIVE);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  logic              isActive;
  logic              isOrigin;
  logic              fbEdge;
  logic              doSwap;
  logic [10:0]       hcntScaled;
  logic [10:0]       vcntScaled;
  logic [ADDR_W-1:0] addrNext;
  logic [0:0]        swapState;

  logic [PIPE_D-1:0] actPipe;
  logic [PIPE_D-1:0] hsyncPipe;
  logic [PIPE_D-1:0] vsyncPipe;
  logic [PIPE_D-1:0] originPipe;

  // Decode the current counts: visibility, frame origin, frame boundary and the scaled read address.
  // The address is computed directly at ADDR_W bits. This is safe because an active pixel never exceeds the buffer size.
  always_comb begin
    isActive   = (hcnt < H_LIM) && (vcnt < V_LIM);
    isOrigin   = (hcnt == 11'd0) && (vcnt == 11'd0);
    fbEdge     = (hcnt == 11'd0) && (vcnt == V_LIM);
    hcntScaled = hcnt >> SCALE_SHIFT;
    vcntScaled = vcnt >> SCALE_SHIFT;
    addrNext   = '0;
    if (isActive) begin
      addrNext = ADDR_W'(vcntScaled) * ADDR_W'(FB_WIDTH) + ADDR_W'(hcntScaled);
    end
    doSwap = fbEdge && ((swapState == ST_PENDING) || fb_swap_req);
  end

  // Register the read address; blank regions read word 0.
  always_ff @(posedge CLK25 or posedge reset) begin
    if (reset) begin
      rd_addr <= '0;
    end else begin
      rd_addr <= addrNext;
    end
  end

  // Bank flip control: remember a request until the next frame boundary, then toggle and acknowledge once.
  always_ff @(posedge CLK25 or posedge reset) begin
    if (reset) begin
      swapState   <= ST_IDLE;
      rd_bank     <= 1'b0;
      fb_swap_ack <= 1'b0;
    end else begin
      fb_swap_ack <= doSwap;
      if (doSwap) begin
        rd_bank   <= ~rd_bank;
        swapState <= ST_IDLE;
      end else if (fb_swap_req) begin
        swapState <= ST_PENDING;
      end
    end
  end

  // Delay the visibility, sync and origin flags so they stay aligned with the frame-buffer read latency.
  always_ff @(posedge CLK25 or posedge reset) begin
    if (reset) begin
      actPipe    <= '0;
      hsyncPipe  <= '1;
      vsyncPipe  <= '1;
      originPipe <= '0;
    end else begin
      actPipe[0]    <= isActive;
      hsyncPipe[0]  <= hsync_in;
      vsyncPipe[0]  <= vsync_in;
      originPipe[0] <= isOrigin;
      for (int i = 1; i < PIPE_D; i++) begin
        actPipe[i]    <= actPipe[i-1];
        hsyncPipe[i]  <= hsyncPipe[i-1];
        vsyncPipe[i]  <= vsyncPipe[i-1];
        originPipe[i] <= originPipe[i-1];
      end
    end
  end

  // Final output register: colour is forced to black outside the visible area.
  always_ff @(posedge CLK25 or posedge reset) begin
    if (reset) begin
      vga_r       <= 4'd0;
      vga_g       <= 4'd0;
      vga_b       <= 4'd0;
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      vga_blank_n <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      vga_r       <= actPipe[PIPE_D-1] ? rd_data[11:8] : 4'd0;
      vga_g       <= actPipe[PIPE_D-1] ? rd_data[7:4]  : 4'd0;
      vga_b       <= actPipe[PIPE_D-1] ? rd_data[3:0]  : 4'd0;
      vga_hsync   <= hsyncPipe[PIPE_D-1];
      vga_vsync   <= vsyncPipe[PIPE_D-1];
      vga_blank_n <= actPipe[PIPE_D-1];
      frame_start <= originPipe[PIPE_D-1];
    end
  end

endmodule
